etc_lane_fsm: RTL and testbench

ETC_LANE_FSM -- requirements
Module: etc_lane_fsm

---
 rtl/etc_pkg.sv | 53 +++++
 rtl/etc_timer.sv | 32 +++
 rtl/etc_lane_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_etc_lane_fsm.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared definitions for the ETC lane controller: FSM states, bus width default, barrier command encoding.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package etc_pkg;

  localparam int FEE_W_DEFAULT = 16;

  // Lane controller states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TAG  = 3'd1,
    CHECK     = 3'd2,
    OPEN      = 3'd3,
    WAIT_PASS = 3'd4,
    CLOSE_DLY = 3'd5,
    REJECT    = 3'd6
  } state_e;

  // The FSM selects at most one barrier command per cycle, which keeps
  // up/down/en/dis mutually exclusive by construction.
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_INIT = 3'd1,
    CMD_UP   = 3'd2,
    CMD_DOWN = 3'd3,
    CMD_EN   = 3'd4,
    CMD_DIS  = 3'd5
  } cmd_e;

  // Bit positions of the decoded command vector {init, up, down, en, dis}.
  localparam int CMD_W        = 5;
  localparam int CMD_BIT_INIT = 4;
  localparam int CMD_BIT_UP   = 3;
  localparam int CMD_BIT_DOWN = 2;
  localparam int CMD_BIT_EN   = 1;
  localparam int CMD_BIT_DIS  = 0;

  // Expand an encoded command into its one-hot pulse vector.
  function automatic logic [CMD_W-1:0] cmd_decode(input cmd_e c);
    logic [CMD_W-1:0] v;
    v = '0;
    case (c)
      CMD_INIT: v[CMD_BIT_INIT] = 1'b1;
      CMD_UP:   v[CMD_BIT_UP]   = 1'b1;
      CMD_DOWN: v[CMD_BIT_DOWN] = 1'b1;
      CMD_EN:   v[CMD_BIT_EN]   = 1'b1;
      CMD_DIS:  v[CMD_BIT_DIS]  = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/etc_timer.sv
// Loadable down-counter shared between the tag timeout and the barrier close delay.
// Latency: zero asserts exactly `value` cycles after the cycle in which load is high.
// Backpressure: none; load always wins over counting.
module etc_timer
  import etc_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  // The load cycle counts as the first elapsed cycle, so the stored count is value-1;
  // the counter then parks at zero until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= (value == '0) ? '0 : value - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/etc_lane_fsm.sv
// Electronic toll lane controller: vehicle/tag sequencing, balance check and deduction, barrier commands.
// Latency: command pulses and deduct_valid are combinational in the transition cycle; new_balance is valid with deduct_valid.
// Backpressure: none; inputs are sampled every cycle. Optional ETC_TXN_COUNT_EN adds a saturating txn_count output.
module etc_lane_fsm
  import etc_pkg::*;
#(
  parameter int FEE_W       = FEE_W_DEFAULT,
  parameter int TAG_TIMEOUT = 1000,
  parameter int CLOSE_DELAY = 50
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             veh_arrive,
  input  logic             veh_pass,
  input  logic             tag_valid,
  input  logic [FEE_W-1:0] tag_balance,
  input  logic [FEE_W-1:0] toll_fee,
  input  logic             manual_open,
  output logic             init,
  output logic             up,
  output logic             down,
  output logic             en,
  output logic             dis,
  output logic             deduct_valid,
  output logic [FEE_W-1:0] new_balance,
  output logic             alarm
`ifdef ETC_TXN_COUNT_EN
  ,
  output logic [15:0]      txn_count
`endif
);

  // One timer serves both phases, so it is sized for the longer interval.
  localparam int TMR_MAX = (TAG_TIMEOUT > CLOSE_DELAY) ? TAG_TIMEOUT : CLOSE_DELAY;
  localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TAG_LOAD   = TMR_W'(TAG_TIMEOUT);
  localparam logic [TMR_W-1:0] CLOSE_LOAD = TMR_W'(CLOSE_DELAY);

  state_e             state_q;
  state_e             state_d;
  cmd_e               cmd;
  logic               deduct;
  logic               bal_latch;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_zero;
  logic [FEE_W-1:0]   bal_q;
  logic [FEE_W-1:0]   new_bal_q;
  logic [FEE_W-1:0]   diff;
  logic               pass_q;
  logic               manual_q;
  logic               pass_rise;
  logic               manual_rise;
  logic               manual_take;
  logic               fee_ok;
  logic [CMD_W-1:0]   cmd_vec;

  etc_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_val),
    .zero    (tmr_zero)
  );

  assign pass_rise   = veh_pass & ~pass_q;
  assign manual_rise = manual_open & ~manual_q;
  // The operator override is ignored once the barrier is already going up or is up.
  assign manual_take = manual_rise && (state_q != OPEN) && (state_q != WAIT_PASS);
  assign fee_ok      = (bal_q >= toll_fee);
  assign diff        = bal_q - toll_fee;

  // State register; async reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Previous levels of the exit loop and operator switch for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_q   <= 1'b0;
      manual_q <= 1'b0;
    end else begin
      pass_q   <= veh_pass;
      manual_q <= manual_open;
    end
  end

  // Next-state and command selection; manual override has top priority outside OPEN/WAIT_PASS.
  always_comb begin
    state_d   = state_q;
    cmd       = CMD_NONE;
    deduct    = 1'b0;
    bal_latch = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    if (manual_take) begin
      state_d = WAIT_PASS;
      cmd     = CMD_UP;
    end else begin
      case (state_q)
        IDLE: begin
          if (veh_arrive) begin
            state_d  = WAIT_TAG;
            cmd      = CMD_INIT;
            tmr_load = 1'b1;
            tmr_val  = TAG_LOAD;
          end
        end
        WAIT_TAG: begin
          // A tag seen on the final timer cycle still counts as in time.
          if (tag_valid) begin
            state_d   = CHECK;
            bal_latch = 1'b1;
          end else if (tmr_zero) begin
            state_d = REJECT;
            cmd     = CMD_DIS;
          end else if (!veh_arrive) begin
            state_d = IDLE;
            cmd     = CMD_DIS;
          end
        end
        CHECK: begin
          if (fee_ok) begin
            state_d = OPEN;
            cmd     = CMD_EN;
            deduct  = 1'b1;
          end else begin
            state_d = REJECT;
            cmd     = CMD_DIS;
          end
        end
        OPEN: begin
          state_d = WAIT_PASS;
        end
        WAIT_PASS: begin
          // No timeout here: the barrier only closes once a vehicle has cleared the exit loop.
          if (pass_rise) begin
            state_d  = CLOSE_DLY;
            tmr_load = 1'b1;
            tmr_val  = CLOSE_LOAD;
          end
        end
        CLOSE_DLY: begin
          // A following vehicle on the exit loop restarts the delay instead of closing on it.
          if (pass_rise) begin
            tmr_load = 1'b1;
            tmr_val  = CLOSE_LOAD;
          end else if (tmr_zero) begin
            state_d = IDLE;
            cmd     = CMD_DOWN;
          end
        end
        REJECT: begin
          if (!veh_arrive) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Commands are Mealy outputs; gating with reset_n keeps them quiet while reset is held.
  assign cmd_vec      = reset_n ? cmd_decode(cmd) : '0;
  assign init         = cmd_vec[CMD_BIT_INIT];
  assign up           = cmd_vec[CMD_BIT_UP];
  assign down         = cmd_vec[CMD_BIT_DOWN];
  assign en           = cmd_vec[CMD_BIT_EN];
  assign dis          = cmd_vec[CMD_BIT_DIS];
  assign deduct_valid = deduct & reset_n;
  assign alarm        = (state_q == REJECT);

  // Latched tag balance and the held post-deduction balance; rejects never touch new_bal_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bal_q     <= '0;
      new_bal_q <= '0;
    end else begin
      if (bal_latch) begin
        bal_q <= tag_balance;
      end
      if (deduct_valid) begin
        new_bal_q <= diff;
      end
    end
  end

  // The fresh result is forwarded in the deduction cycle, then held from the register.
  assign new_balance = deduct_valid ? diff : new_bal_q;

`ifdef ETC_TXN_COUNT_EN
  // Saturating count of completed deductions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_count <= '0;
    end else if (deduct_valid && (txn_count != 16'hFFFF)) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_etc_lane_fsm.sv
// Bench for etc_lane_fsm: balance/fee table plus hand-written timeout, tailgate, override and reset sequences.
// Every command pulse must match the head of an expected-pulse queue (kind, cycle, new_balance).
// Builds with or without ETC_TXN_COUNT_EN.
module tb_etc_lane_fsm;

  localparam int FW    = 16;
  localparam int TAG   = 1000;
  localparam int CLOSE = 50;

  // Pulse vector order: {init, up, down, en, dis, deduct_valid}
  localparam logic [5:0] P_INIT = 6'b100000;
  localparam logic [5:0] P_UP   = 6'b010000;
  localparam logic [5:0] P_DOWN = 6'b001000;
  localparam logic [5:0] P_PASS = 6'b000101;
  localparam logic [5:0] P_DIS  = 6'b000010;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          veh_arrive, veh_pass, tag_valid, manual_open;
  logic [FW-1:0] tag_balance, toll_fee;
  logic          init, up, down, en, dis, deduct_valid, alarm;
  logic [FW-1:0] new_balance;
`ifdef ETC_TXN_COUNT_EN
  logic [15:0]   txn_count;
`endif

  always #5 clk = ~clk;

  etc_lane_fsm #(
    .FEE_W(FW), .TAG_TIMEOUT(TAG), .CLOSE_DELAY(CLOSE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .veh_arrive(veh_arrive), .veh_pass(veh_pass),
    .tag_valid(tag_valid), .tag_balance(tag_balance),
    .toll_fee(toll_fee), .manual_open(manual_open),
    .init(init), .up(up), .down(down), .en(en), .dis(dis),
    .deduct_valid(deduct_valid), .new_balance(new_balance), .alarm(alarm)
`ifdef ETC_TXN_COUNT_EN
    , .txn_count(txn_count)
`endif
  );

  typedef struct {
    logic [5:0]    pulses;
    logic [FW-1:0] nb;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [FW-1:0] bal;
    logic [FW-1:0] fee;
    logic          pass;
    logic [FW-1:0] nb;
  } vec_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_txn = 0;
  logic [FW-1:0] nb_hold = '0;
  logic [5:0]    mon_p;
  exp_t          mon_e;
  vec_t          tbl[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [5:0] p, input logic [FW-1:0] nb, input int at);
    exp_t e;
    e.pulses = p;
    e.nb     = nb;
    e.cyc    = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    check(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Scoreboard: any command pulse must be the next expected one, at the expected cycle.
  always @(negedge clk) begin
    mon_p = {init, up, down, en, dis, deduct_valid};
    if (mon_p != 6'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(mon_p), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", 32'(mon_p), 32'(mon_e.pulses));
        if (mon_e.cyc >= 0) check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.pulses[0]) check("deduct_balance", 32'(new_balance), 32'(mon_e.nb));
      end
    end
  end

  // IDLE -> tag presented -> CHECK; returns in the OPEN or REJECT cycle.
  task automatic start_txn(input logic [FW-1:0] bal, input logic [FW-1:0] fee,
                           input logic pass, input logic [FW-1:0] nb);
    toll_fee   = fee;
    veh_arrive = 1'b1;
    expect_pulse(P_INIT, '0, cyc);
    tick();
    tag_valid   = 1'b1;
    tag_balance = bal;
    expect_pulse(pass ? P_PASS : P_DIS, nb, cyc + 1);
    tick();
    tag_valid   = 1'b0;
    tag_balance = FW'($urandom);
    tick();
    if (pass) begin
      exp_txn++;
      nb_hold = nb;
    end
  endtask

  // From WAIT_PASS: one exit-loop pulse, barrier must go down CLOSE cycles later.
  task automatic close_gate();
    veh_pass = 1'b1;
    expect_pulse(P_DOWN, '0, cyc + CLOSE);
    tick();
    veh_pass = 1'b0;
    tick(CLOSE + 2);
  endtask

  task automatic run_vec(input vec_t v);
    start_txn(v.bal, v.fee, v.pass, v.nb);
    if (v.pass) begin
      check("open_balance", 32'(new_balance), 32'(v.nb));
      check("open_alarm", 32'(alarm), 32'd0);
      tick();
      veh_arrive = 1'b0;
      tick(3);
      close_gate();
      check("balance_hold", 32'(new_balance), 32'(v.nb));
    end else begin
      check("reject_alarm", 32'(alarm), 32'd1);
      check("reject_no_deduct", 32'(new_balance), 32'(nb_hold));
      veh_arrive = 1'b0;
      tick();
      check("reject_exit_alarm", 32'(alarm), 32'd0);
      tick(2);
    end
    drain("vec_drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'd500,   16'd120,   1'b1, 16'd380};
    tbl[1] = '{16'd100,   16'd120,   1'b0, 16'd0};
    tbl[2] = '{16'd120,   16'd120,   1'b1, 16'd0};
    tbl[3] = '{16'd0,     16'd0,     1'b1, 16'd0};
    tbl[4] = '{16'd65535, 16'd1,     1'b1, 16'd65534};
    tbl[5] = '{16'd0,     16'd1,     1'b0, 16'd0};
    tbl[6] = '{16'd119,   16'd120,   1'b0, 16'd0};
    tbl[7] = '{16'd65535, 16'd65535, 1'b1, 16'd0};
    tbl[8] = '{16'd1,     16'd0,     1'b1, 16'd1};

    // Reset with active-looking inputs: nothing may pulse.
    reset_n = 1'b0; veh_arrive = 1'b1; veh_pass = 1'b0; tag_valid = 1'b0;
    manual_open = 1'b1; tag_balance = '0; toll_fee = '0;
    tick(3);
    check("rst_cmds", 32'({init, up, down, en, dis, deduct_valid}), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_new_balance", 32'(new_balance), 32'd0);
`ifdef ETC_TXN_COUNT_EN
    check("rst_txn_count", 32'(txn_count), 32'd0);
`endif
    veh_arrive = 1'b0; manual_open = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(2);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Tag timeout: reject on the 1000th WAIT_TAG cycle, later tags ignored.
    toll_fee = 16'd120; veh_arrive = 1'b1;
    expect_pulse(P_INIT, '0, cyc);
    tick();
    expect_pulse(P_DIS, '0, cyc + TAG - 1);
    tick(TAG);
    check("timeout_alarm", 32'(alarm), 32'd1);
    tag_valid = 1'b1; tag_balance = 16'd500;
    tick();
    tag_valid = 1'b0;
    check("late_tag_alarm", 32'(alarm), 32'd1);
    check("late_tag_balance", 32'(new_balance), 32'(nb_hold));
    tick(2);
    veh_arrive = 1'b0;
    tick();
    check("timeout_exit_alarm", 32'(alarm), 32'd0);
    drain("timeout_drain");

    // Tag on the last permitted WAIT_TAG cycle is still accepted.
    veh_arrive = 1'b1;
    expect_pulse(P_INIT, '0, cyc);
    tick();
    tick(TAG - 1);
    tag_valid = 1'b1; tag_balance = 16'd500;
    expect_pulse(P_PASS, 16'd380, cyc + 1);
    tick();
    tag_valid = 1'b0;
    exp_txn++; nb_hold = 16'd380;
    tick(2);
    veh_arrive = 1'b0;
    close_gate();
    drain("last_tag_drain");

    // Vehicle leaves the entry loop before presenting a tag.
    veh_arrive = 1'b1;
    expect_pulse(P_INIT, '0, cyc);
    tick(5);
    veh_arrive = 1'b0;
    expect_pulse(P_DIS, '0, cyc);
    tick();
    check("leave_alarm", 32'(alarm), 32'd0);
    tick(3);
    drain("leave_drain");

    // Tailgate: second exit-loop edge 20 cycles into the delay restarts it.
    start_txn(16'd120, 16'd120, 1'b1, 16'd0);
    tick();
    veh_arrive = 1'b0;
    veh_pass = 1'b1;
    tick();
    veh_pass = 1'b0;
    tick(19);
    veh_pass = 1'b1;
    expect_pulse(P_DOWN, '0, cyc + CLOSE);
    tick();
    veh_pass = 1'b0;
    tick(CLOSE + 3);
    check("tailgate_balance", 32'(new_balance), 32'd0);
    drain("tailgate_drain");

    // Manual override from REJECT, then ignored while already in WAIT_PASS.
    start_txn(16'd100, 16'd120, 1'b0, 16'd0);
    check("manual_pre_alarm", 32'(alarm), 32'd1);
    manual_open = 1'b1;
    expect_pulse(P_UP, '0, cyc);
    tick();
    check("manual_alarm_clr", 32'(alarm), 32'd0);
    veh_arrive = 1'b0;
    tick(2);
    manual_open = 1'b0;
    tick();
    manual_open = 1'b1;
    tick();
    manual_open = 1'b0;
    tick();
`ifdef ETC_TXN_COUNT_EN
    check("txn_count_before_rst", 32'(txn_count), 32'(exp_txn));
`endif

    // Reset while in WAIT_PASS: outputs cleared, counter back to zero.
    reset_n = 1'b0; veh_arrive = 1'b1; manual_open = 1'b1;
    #1;
    check("wp_rst_cmds", 32'({init, up, down, en, dis, deduct_valid}), 32'd0);
    check("wp_rst_alarm", 32'(alarm), 32'd0);
    check("wp_rst_balance", 32'(new_balance), 32'd0);
`ifdef ETC_TXN_COUNT_EN
    check("wp_rst_txn_count", 32'(txn_count), 32'd0);
`endif
    tick(2);
    nb_hold = '0;
    manual_open = 1'b0;
    expect_pulse(P_INIT, '0, cyc);
    reset_n = 1'b1;
    tick();
    // Override beats a same-cycle tag.
    manual_open = 1'b1; tag_valid = 1'b1; tag_balance = 16'd500;
    expect_pulse(P_UP, '0, cyc);
    tick();
    manual_open = 1'b0; tag_valid = 1'b0; veh_arrive = 1'b0;
    tick(2);
    close_gate();
    check("override_no_deduct", 32'(new_balance), 32'd0);
    drain("override_drain");

    // Reset during CHECK: no deduction survives.
    veh_arrive = 1'b1; toll_fee = 16'd120;
    expect_pulse(P_INIT, '0, cyc);
    tick();
    tag_valid = 1'b1; tag_balance = 16'd500;
    tick();
    reset_n = 1'b0; tag_valid = 1'b0;
    tick();
    reset_n = 1'b1; veh_arrive = 1'b0;
    tick(3);
    check("check_rst_balance", 32'(new_balance), 32'd0);
    check("check_rst_alarm", 32'(alarm), 32'd0);
`ifdef ETC_TXN_COUNT_EN
    check("check_rst_txn_count", 32'(txn_count), 32'd0);
`endif
    drain("check_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
